// File: rtl/seg_addsub.sv
// seg_addsub: segmented two's-complement adder/subtractor.
// The carry chain is cut into SEG-bit slices and one slice is added per clock,
// so the combinational path is one SEG-bit adder regardless of WIDTH.
// Optional feature macro: SEG_ADDSUB_OVF_EN (signed overflow flag on ovf).
module seg_addsub #(
  parameter int WIDTH = 26,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG  = (WIDTH + SEG - 1) / SEG;
  localparam int KW    = (NSEG > 1) ? $clog2(NSEG) : 1;
  // Width of the top slice; its carry-out lands on this bit of the slice sum
  // because the padding above WIDTH is zero in both operands.
  localparam int LASTW = WIDTH - (NSEG - 1) * SEG;
  localparam logic [KW-1:0] K_LAST = KW'(NSEG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;        // already inverted for subtraction
  logic             r_sub;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;

  logic [SEG-1:0]   w_a_seg [NSEG];
  logic [SEG-1:0]   w_b_seg [NSEG];
  logic [SEG-1:0]   w_a_slice;
  logic [SEG-1:0]   w_b_slice;
  logic [SEG:0]     w_sum;
  logic             w_carry_out;
  logic             w_last;
  logic [WIDTH-1:0] w_result_next;

  // Split the latched operands into zero-padded slices.
  for (genvar gs = 0; gs < NSEG; gs++) begin : g_seg
    for (genvar gi = 0; gi < SEG; gi++) begin : g_bit
      if (gs * SEG + gi < WIDTH) begin : g_real
        assign w_a_seg[gs][gi] = r_a[gs*SEG+gi];
        assign w_b_seg[gs][gi] = r_b[gs*SEG+gi];
      end else begin : g_pad
        assign w_a_seg[gs][gi] = 1'b0;
        assign w_b_seg[gs][gi] = 1'b0;
      end
    end
  end

  assign w_a_slice   = w_a_seg[r_k];
  assign w_b_slice   = w_b_seg[r_k];
  assign w_sum       = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{SEG{1'b0}}, r_carry};
  assign w_last      = (r_k == K_LAST);
  assign w_carry_out = w_last ? w_sum[LASTW] : w_sum[SEG];

  // Only the bits of the active slice take the new sum; the rest hold.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_res
    localparam logic [KW-1:0] SI = KW'(gi / SEG);
    assign w_result_next[gi] = (r_state == S_RUN && r_k == SI) ? w_sum[gi % SEG]
                                                               : r_result[gi];
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign cout      = r_cout;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, slice carry propagation and result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_k      <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_result <= w_result_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_sub   <= sub;
            r_carry <= sub;
            r_k     <= '0;
          end
        end
        S_RUN: begin
          r_carry <= w_carry_out;
          if (w_last) begin
            r_k    <= '0;
            // Subtraction reports a borrow, which is the inverted carry.
            r_cout <= w_carry_out ^ r_sub;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEG_ADDSUB_OVF_EN
  logic r_ovf;
  logic w_ovf_next;

  // With b pre-inverted for subtraction, both cases reduce to: operand signs
  // equal and result sign differs.
  assign w_ovf_next = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[LASTW-1] != r_a[WIDTH-1]);

  // Overflow flag captured alongside the top slice.
  always_ff @(posedge clk) begin
    if (rst)                             r_ovf <= 1'b0;
    else if (r_state == S_RUN && w_last) r_ovf <= w_ovf_next;
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seg_addsub.sv
// Directed self-checking bench for seg_addsub (26/8 and 5/2 configurations).
module tb_seg_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [25:0] a = '0;
  logic [25:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [25:0] result;
  logic        cout;
  logic        ovf;

  logic        in_valid5 = 1'b0;
  logic        in_ready5;
  logic [4:0]  a5 = '0;
  logic [4:0]  b5 = '0;
  logic        sub5 = 1'b0;
  logic        out_valid5;
  logic        out_ready5 = 1'b0;
  logic [4:0]  result5;
  logic        cout5;
  logic        ovf5;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SEG_ADDSUB_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  seg_addsub #(.WIDTH(26), .SEG(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf)
  );

  seg_addsub #(.WIDTH(5), .SEG(2)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
    .a(a5), .b(b5), .sub(sub5), .out_valid(out_valid5), .out_ready(out_ready5),
    .result(result5), .cout(cout5), .ovf(ovf5)
  );

  // Present one operation, return cycles from accept edge to out_valid (99 on timeout).
  task automatic start26(input logic [25:0] ta, input logic [25:0] tb_v, input logic ts,
                         output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) lat = 99;
  endtask

  task automatic ack26();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic start5(input logic [4:0] ta, input logic [4:0] tb_v, input logic ts,
                        output int lat);
    int n;
    n = 0;
    while (!in_ready5 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    a5 = ta; b5 = tb_v; sub5 = ts; in_valid5 = 1'b1;
    @(posedge clk); #1;
    in_valid5 = 1'b0;
    lat = 0;
    while (!out_valid5 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid5) lat = 99;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++;
    if ({out_valid, cout, ovf} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b expected 000", {out_valid, cout, ovf}); end
    n_checks++;
    if (result !== 26'h0) begin n_errors++; $display("FAIL reset_result: got %h expected 0000000", result); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    $display("reset: in_ready=%b out_valid=%b result=%h", in_ready, out_valid, result);
  endtask

  task automatic test_sub();
    logic [25:0] va [3];
    logic [25:0] vb [3];
    logic [25:0] vr [3];
    logic        vc [3];
    int lat;
    va[0] = 26'h0000002; vb[0] = 26'h3FFFFFF; vr[0] = 26'h0000003; vc[0] = 1'b1;
    va[1] = 26'h3FFFFFF; vb[1] = 26'h0000002; vr[1] = 26'h3FFFFFD; vc[1] = 1'b0;
    va[2] = 26'h0000002; vb[2] = 26'h0000002; vr[2] = 26'h0000000; vc[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start26(va[i], vb[i], 1'b1, lat);
      n_checks++;
      if (lat !== 4) begin n_errors++; $display("FAIL sub%0d_latency: got %0d expected 4", i, lat); end
      n_checks++;
      if (result !== vr[i]) begin n_errors++; $display("FAIL sub%0d_result: got %h expected %h", i, result, vr[i]); end
      n_checks++;
      if (cout !== vc[i]) begin n_errors++; $display("FAIL sub%0d_cout: got %b expected %b", i, cout, vc[i]); end
      n_checks++;
      if (ovf !== 1'b0) begin n_errors++; $display("FAIL sub%0d_ovf: got %b expected 0", i, ovf); end
      $display("sub %h-%h: result=%h cout=%b ovf=%b lat=%0d", va[i], vb[i], result, cout, ovf, lat);
      ack26();
    end
  endtask

  task automatic test_add();
    int lat;
    start26(26'h3FFFFFF, 26'h0000001, 1'b0, lat);
    n_checks++;
    if (lat !== 4) begin n_errors++; $display("FAIL add_latency: got %0d expected 4", lat); end
    n_checks++;
    if (result !== 26'h0000000) begin n_errors++; $display("FAIL add_result: got %h expected 0000000", result); end
    n_checks++;
    if (cout !== 1'b1) begin n_errors++; $display("FAIL add_cout: got %b expected 1", cout); end
    $display("add 3ffffff+0000001: result=%h cout=%b ovf=%b", result, cout, ovf);
    ack26();
  endtask

  task automatic test_ovf();
    int lat;
    start26(26'h1FFFFFF, 26'h0000001, 1'b0, lat);
    n_checks++;
    if (result !== 26'h2000000) begin n_errors++; $display("FAIL ovf_add_result: got %h expected 2000000", result); end
    n_checks++;
    if ({cout, ovf} !== {1'b0, OVF_EXP}) begin n_errors++; $display("FAIL ovf_add_flags: got cout=%b ovf=%b expected cout=0 ovf=%b", cout, ovf, OVF_EXP); end
    $display("add 1ffffff+0000001: result=%h cout=%b ovf=%b", result, cout, ovf);
    ack26();
    start26(26'h2000000, 26'h0000001, 1'b1, lat);
    n_checks++;
    if (result !== 26'h1FFFFFF) begin n_errors++; $display("FAIL ovf_sub_result: got %h expected 1ffffff", result); end
    n_checks++;
    if ({cout, ovf} !== {1'b0, OVF_EXP}) begin n_errors++; $display("FAIL ovf_sub_flags: got cout=%b ovf=%b expected cout=0 ovf=%b", cout, ovf, OVF_EXP); end
    $display("sub 2000000-0000001: result=%h cout=%b ovf=%b", result, cout, ovf);
    ack26();
  endtask

  task automatic test_backpressure();
    int lat;
    start26(26'h0000005, 26'h0000007, 1'b0, lat);
    a = 26'h0000100; b = 26'h0000200; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b10) begin n_errors++; $display("FAIL bp_hold%0d_handshake: got out_valid=%b in_ready=%b expected 1 0", i, out_valid, in_ready); end
      n_checks++;
      if ({result, cout} !== {26'h000000C, 1'b0}) begin n_errors++; $display("FAIL bp_hold%0d_data: got %h/%b expected 000000c/0", i, result, cout); end
    end
    $display("backpressure: held result=%h cout=%b for 5 cycles", result, cout);
    in_valid = 1'b0;
    ack26();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin n_errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
    // Accept immediately on the following edge.
    a = 26'h0000010; b = 26'h0000003; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_next_accept: got in_ready=%b expected 0", in_ready); end
    repeat (4) begin @(posedge clk); #1; end
    n_checks++;
    if ({out_valid, result, cout} !== {1'b1, 26'h000000D, 1'b0}) begin n_errors++; $display("FAIL bp_next_result: got v=%b %h/%b expected v=1 000000d/0", out_valid, result, cout); end
    $display("backpressure next op: result=%h cout=%b", result, cout);
    ack26();
  endtask

  task automatic test_reset_midrun();
    logic seen;
    a = 26'h0000123; b = 26'h0000456; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready, cout, ovf} !== 4'b0000) begin n_errors++; $display("FAIL midrst_flags: got %b expected 0000", {out_valid, in_ready, cout, ovf}); end
    n_checks++;
    if (result !== 26'h0) begin n_errors++; $display("FAIL midrst_result: got %h expected 0000000", result); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_ready: got %b expected 1", in_ready); end
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_errors++; $display("FAIL midrst_no_valid: got %b expected 0", seen); end
    $display("reset mid-run: out_valid_seen=%b in_ready=%b", seen, in_ready);
  endtask

  task automatic test_w5();
    int lat;
    start5(5'd3, 5'd4, 1'b1, lat);
    n_checks++;
    if (lat !== 3) begin n_errors++; $display("FAIL w5_sub_latency: got %0d expected 3", lat); end
    n_checks++;
    if ({result5, cout5, ovf5} !== {5'h1F, 1'b1, 1'b0}) begin n_errors++; $display("FAIL w5_sub: got %h/%b/%b expected 1f/1/0", result5, cout5, ovf5); end
    $display("w5 sub 3-4: result=%h cout=%b lat=%0d", result5, cout5, lat);
    out_ready5 = 1'b1; @(posedge clk); #1; out_ready5 = 1'b0;
    start5(5'd17, 5'd15, 1'b0, lat);
    n_checks++;
    if ({result5, cout5} !== {5'h00, 1'b1}) begin n_errors++; $display("FAIL w5_add: got %h/%b expected 00/1", result5, cout5); end
    $display("w5 add 17+15: result=%h cout=%b", result5, cout5);
    out_ready5 = 1'b1; @(posedge clk); #1; out_ready5 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sub();
    test_add();
    test_ovf();
    test_backpressure();
    test_reset_midrun();
    test_w5();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
